// File: rtl/rail_sequencer_if.sv
// Wishbone slave bus bundle for rail_sequencer (16-bit address/data).
interface rail_sequencer_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [15:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/rail_sequencer.sv
// Power rail sequencer: ordered power-up with PG timeout, reverse-order
// power-down, hard-fault shutdown and a Wishbone command/status slave.
// Optional feature macro: RAIL_SEQ_AUTO_RESTART_EN (automatic retry after fault).
module rail_sequencer #(
    parameter int unsigned           NUM_RAILS       = 8,
    parameter logic [31:0]           PG_TIMEOUT      = 32'd1000,
    parameter logic [31:0]           STEP_DELAY      = 32'd100,
    parameter logic [31:0]           POWER_DOWN_WAIT = 32'd100,
    parameter logic [NUM_RAILS-1:0]  INHIBIT_MASK    = {NUM_RAILS{1'b0}}
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    rail_sequencer_if.slave      wb,
    input  logic                 power_up_req,
    input  logic                 power_down_req,
    input  logic                 fault_i,
    input  logic [NUM_RAILS-1:0] rail_pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 power_ok,
    output logic                 seq_fault
);

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_UP_EN   = 4'd1,
        ST_UP_PG   = 4'd2,
        ST_UP_STEP = 4'd3,
        ST_ON      = 4'd4,
        ST_DN_DIS  = 4'd5,
        ST_DN_WAIT = 4'd6,
        ST_FAULT   = 4'd7
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_RAILS - 1);
`ifdef RAIL_SEQ_AUTO_RESTART_EN
    localparam logic [31:0] RESTART_WAIT = POWER_DOWN_WAIT * 32'd4;
`endif

    state_t                 state_q, state_nx;
    logic [3:0]             idx_q, idx_nx;
    logic [31:0]            timer_q, timer_nx, timer_inc;
    logic [NUM_RAILS-1:0]   en_q, en_nx;
    logic [NUM_RAILS-1:0]   mask_q;
    logic [1:0]             cause_q, cause_nx;
    logic [3:0]             frail_q, frail_nx;
    logic [3:0]             retry_q, retry_nx;
    logic [NUM_RAILS-1:0]   pg_meta, pg_sync;

    logic                   ack_q;
    logic [15:0]            dat_q, rd_data;
    logic                   wb_req, ctrl_wr, mask_wr;
    logic                   cmd_up, cmd_dn, cmd_clr;

    logic [NUM_RAILS-1:0]   idx_onehot;
    logic                   sel_mask, sel_pg, pg_lost;
    logic [3:0]             lost_idx;
    logic                   unused_dat;

    assign unused_dat = ^wb.wb_dat_i;

    // Wishbone request decode and command pulses (down beats up)
    always_comb begin
        wb_req  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        ctrl_wr = wb_req & wb.wb_we_i & (wb.wb_adr_i == 16'd1);
        mask_wr = wb_req & wb.wb_we_i & (wb.wb_adr_i == 16'd4);
        cmd_dn  = power_down_req | (ctrl_wr & wb.wb_dat_i[1]);
        cmd_up  = (power_up_req | (ctrl_wr & wb.wb_dat_i[0])) & ~cmd_dn;
        cmd_clr = ctrl_wr & wb.wb_dat_i[2];
    end

    // Two-flop synchroniser for the asynchronous PG inputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            pg_meta <= '0;
            pg_sync <= '0;
        end else begin
            pg_meta <= rail_pg;
            pg_sync <= pg_meta;
        end
    end

    // Per-index selection and lowest-index PG-loss detection
    always_comb begin
        idx_onehot = '0;
        sel_mask   = 1'b0;
        sel_pg     = 1'b0;
        pg_lost    = 1'b0;
        lost_idx   = '0;
        for (int unsigned i = 0; i < NUM_RAILS; i++) begin
            if (idx_q == 4'(i)) begin
                idx_onehot[i] = 1'b1;
                sel_mask      = mask_q[i];
                sel_pg        = pg_sync[i];
            end
            if (!pg_lost && mask_q[i] && !pg_sync[i]) begin
                pg_lost  = 1'b1;
                lost_idx = 4'(i);
            end
        end
    end

    // FSM state and sequencing datapath registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            timer_q <= '0;
            en_q    <= '0;
            cause_q <= '0;
            frail_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_nx;
            idx_q   <= idx_nx;
            timer_q <= timer_nx;
            en_q    <= en_nx;
            cause_q <= cause_nx;
            frail_q <= frail_nx;
            retry_q <= retry_nx;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_nx  = state_q;
        idx_nx    = idx_q;
        timer_nx  = timer_q;
        en_nx     = en_q;
        cause_nx  = cause_q;
        frail_nx  = frail_q;
        retry_nx  = retry_q;
        timer_inc = (timer_q == '1) ? timer_q : timer_q + 32'd1;

        if (fault_i && state_q != ST_OFF && state_q != ST_FAULT) begin
            state_nx = ST_FAULT;
            cause_nx = 2'd3;
            en_nx    = '0;
            timer_nx = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    if (cmd_up) begin
                        idx_nx   = '0;
                        state_nx = ST_UP_EN;
                    end
                end
                ST_UP_EN, ST_UP_PG, ST_UP_STEP: begin
                    if (cmd_dn) begin
                        state_nx = ST_DN_DIS;
                    end else if (state_q == ST_UP_EN) begin
                        if (!sel_mask) begin
                            if (idx_q == LAST_IDX) begin
                                state_nx = ST_ON;
                                retry_nx = '0;
                            end else begin
                                idx_nx = idx_q + 4'd1;
                            end
                        end else begin
                            en_nx    = en_q | idx_onehot;
                            timer_nx = '0;
                            state_nx = ST_UP_PG;
                        end
                    end else if (state_q == ST_UP_PG) begin
                        if (sel_pg) begin
                            timer_nx = '0;
                            state_nx = ST_UP_STEP;
                        end else if (timer_q >= PG_TIMEOUT) begin
                            state_nx = ST_FAULT;
                            cause_nx = 2'd1;
                            frail_nx = idx_q;
                            en_nx    = '0;
                            timer_nx = '0;
                        end else begin
                            timer_nx = timer_inc;
                        end
                    end else begin
                        if (timer_q >= STEP_DELAY) begin
                            if (idx_q == LAST_IDX) begin
                                state_nx = ST_ON;
                                retry_nx = '0;
                            end else begin
                                idx_nx   = idx_q + 4'd1;
                                state_nx = ST_UP_EN;
                            end
                        end else begin
                            timer_nx = timer_inc;
                        end
                    end
                end
                ST_ON: begin
                    if (pg_lost) begin
                        state_nx = ST_FAULT;
                        cause_nx = 2'd2;
                        frail_nx = lost_idx;
                        en_nx    = '0;
                        timer_nx = '0;
                    end else if (cmd_dn) begin
                        idx_nx   = LAST_IDX;
                        state_nx = ST_DN_DIS;
                    end
                end
                ST_DN_DIS: begin
                    if (sel_mask) begin
                        en_nx    = en_q & ~idx_onehot;
                        timer_nx = '0;
                        state_nx = ST_DN_WAIT;
                    end else if (idx_q == 4'd0) begin
                        state_nx = ST_OFF;
                    end else begin
                        idx_nx = idx_q - 4'd1;
                    end
                end
                ST_DN_WAIT: begin
                    if (timer_q >= POWER_DOWN_WAIT) begin
                        if (idx_q == 4'd0) begin
                            state_nx = ST_OFF;
                        end else begin
                            idx_nx   = idx_q - 4'd1;
                            state_nx = ST_DN_DIS;
                        end
                    end else begin
                        timer_nx = timer_inc;
                    end
                end
                ST_FAULT: begin
                    if (cmd_clr) begin
                        state_nx = ST_OFF;
                        retry_nx = '0;
                        timer_nx = '0;
                    end
`ifdef RAIL_SEQ_AUTO_RESTART_EN
                    else if (cause_q != 2'd3 && retry_q < 4'd3) begin
                        if (timer_q >= RESTART_WAIT) begin
                            retry_nx = retry_q + 4'd1;
                            idx_nx   = '0;
                            state_nx = ST_UP_EN;
                        end else begin
                            timer_nx = timer_inc;
                        end
                    end
`endif
                end
                default: state_nx = ST_OFF;
            endcase
        end
    end

    // Physical outputs; rails are forced off while in FAULT
    always_comb begin
        power_ok  = (state_q == ST_ON);
        seq_fault = (state_q == ST_FAULT);
        rail_en   = ((state_q == ST_FAULT) ? '0 : en_q) ^ INHIBIT_MASK;
    end

    // Register read multiplexer
    always_comb begin
        rd_data = '0;
        unique case (wb.wb_adr_i)
            16'd0:   rd_data = {retry_q, idx_q, cause_q, seq_fault, power_ok, state_q};
            16'd2:   rd_data = 16'(pg_sync);
            16'd3:   rd_data = {12'd0, frail_q};
            16'd4:   rd_data = 16'(mask_q);
            default: rd_data = '0;
        endcase
    end

    // Wishbone acknowledge, read data and enable-mask register
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            mask_q <= '1;
        end else begin
            ack_q <= wb_req;
            dat_q <= (wb_req && !wb.wb_we_i) ? rd_data : '0;
            if (mask_wr && state_q == ST_OFF) begin
                mask_q <= wb.wb_dat_i[NUM_RAILS-1:0];
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_rail_sequencer.sv
// Directed self-checking bench for rail_sequencer (4 rails, logical PG loopback).
module tb_rail_sequencer;

    localparam logic [3:0] INH = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_req = 1'b0;
    logic       dn_req = 1'b0;
    logic       fault = 1'b0;
    logic [3:0] pg_force = 4'hF;
    logic [3:0] rail_pg;
    logic [3:0] rail_en;
    logic       power_ok;
    logic       seq_fault;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    rail_sequencer_if wb ();

    assign rail_pg = (rail_en ^ INH) & pg_force;

    rail_sequencer #(
        .NUM_RAILS      (4),
        .PG_TIMEOUT     (32'd50),
        .STEP_DELAY     (32'd10),
        .POWER_DOWN_WAIT(32'd10),
        .INHIBIT_MASK   (INH)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst_n),
        .wb            (wb),
        .power_up_req  (up_req),
        .power_down_req(dn_req),
        .fault_i       (fault),
        .rail_pg       (rail_pg),
        .rail_en       (rail_en),
        .power_ok      (power_ok),
        .seq_fault     (seq_fault)
    );

    function automatic logic [3:0] en_log();
        return rail_en ^ INH;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request on one edge, ack expected after it, no ack after the next
    task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                           output logic [15:0] rd);
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        tick();
        check("wb_ack", 32'(wb.wb_ack_o), 32'd1);
        rd = wb.wb_dat_o;
        tick();
        check("wb_ack_single", 32'(wb.wb_ack_o), 32'd0);
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [15:0] adr, input logic [15:0] dat);
        logic [15:0] dummy;
        wb_xfer(1'b1, adr, dat, dummy);
    endtask

    task automatic wb_read(input logic [15:0] adr, output logic [15:0] rd);
        wb_xfer(1'b0, adr, 16'h0000, rd);
    endtask

    task automatic wait_en_change(input int max_cyc, output logic [3:0] nv, output int cyc);
        logic [3:0] prev;
        prev = en_log();
        cyc = 0;
        while (cyc < max_cyc) begin
            tick();
            cyc++;
            if (en_log() != prev) break;
        end
        nv = en_log();
    endtask

    task automatic wait_off(input string tag);
        logic [15:0] st;
        st = 16'hFFFF;
        for (int k = 0; k < 20; k++) begin
            wb_read(16'd0, st);
            if (st[3:0] == 4'd0) break;
        end
        check(tag, 32'(st[3:0]), 32'd0);
    endtask

    // Power up with the given mask; checks enable order, spacing and latency
    task automatic power_up(input logic [3:0] mask);
        logic [3:0] cur, exp_v;
        int c, total;
        bit first;
        exp_v = 4'd0;
        first = 1'b1;
        total = 2;
        wb_write(16'd1, 16'h0001);
        cur = en_log();
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                exp_v[i] = 1'b1;
                if (cur != exp_v) begin
                    wait_en_change(40, cur, c);
                    total += c;
                    if (!first) check("up_gap_ge10", 32'(c >= 10), 32'd1);
                end
                check("up_order", 32'(cur), 32'(exp_v));
                first = 1'b0;
            end
        end
        c = 0;
        while (!power_ok && c < 60) begin
            tick();
            c++;
        end
        total += c;
        check("up_power_ok", 32'(power_ok), 32'd1);
        check("up_within_100", 32'(total <= 100), 32'd1);
    endtask

    // Power down from ON; checks reverse order and spacing, then OFF
    task automatic power_down(input logic [3:0] mask);
        logic [3:0] cur, exp_v;
        int c;
        bit first;
        exp_v = mask;
        first = 1'b1;
        wb_write(16'd1, 16'h0002);
        cur = en_log();
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                exp_v[i] = 1'b0;
                if (cur != exp_v) begin
                    wait_en_change(40, cur, c);
                    if (!first) check("dn_gap_ge10", 32'(c >= 10), 32'd1);
                end
                check("dn_order", 32'(cur), 32'(exp_v));
                first = 1'b0;
            end
        end
        wait_off("dn_state_off");
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  cur;
        int          c;

        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;

        // Reset values
        repeat (3) tick();
        check("rst_rail_en", 32'(rail_en), 32'(INH));
        check("rst_power_ok", 32'(power_ok), 32'd0);
        check("rst_seq_fault", 32'(seq_fault), 32'd0);
        check("rst_ack", 32'(wb.wb_ack_o), 32'd0);
        check("rst_dat", 32'(wb.wb_dat_o), 32'd0);
        rst_n = 1'b1;
        tick();
        wb_read(16'd0, rd);
        check("rst_status", 32'(rd), 32'h0000);
        wb_read(16'd4, rd);
        check("rst_mask", 32'(rd), 32'h000F);

        // Undefined address: reads 0, write ignored
        wb_write(16'd9, 16'hFFFF);
        wb_read(16'd9, rd);
        check("undef_read", 32'(rd), 32'd0);

        // Full up sequence, then status and PG readback
        power_up(4'hF);
        wb_read(16'd0, rd);
        check("on_status_low", 32'(rd[4:0]), 32'h14);
        check("on_status_idx", 32'(rd[11:8]), 32'd3);
        check("on_status_retry", 32'(rd[15:12]), 32'd0);
        wb_read(16'd2, rd);
        check("on_pg_reg", 32'(rd), 32'h000F);

        // Ordered power down
        power_down(4'hF);

        // Abort during UP_PG of rail 1
        wb_write(16'd1, 16'h0001);
        check("abort_en0", 32'(en_log()), 32'h1);
        wait_en_change(40, cur, c);
        check("abort_en1", 32'(cur), 32'h3);
        wb_write(16'd1, 16'h0002);
        check("abort_dis1", 32'(en_log()), 32'h1);
        wait_en_change(40, cur, c);
        check("abort_dis0", 32'(cur), 32'h0);
        check("abort_gap_ge10", 32'(c >= 10), 32'd1);
        wait_off("abort_off");

        // PG timeout on rail 2
        pg_force = 4'b1011;
        wb_write(16'd1, 16'h0001);
        wait_en_change(40, cur, c);
        wait_en_change(40, cur, c);
        check("to_en2", 32'(cur), 32'h7);
        c = 0;
        while (!seq_fault && c < 80) begin
            tick();
            c++;
        end
        check("to_latency", 32'(c), 32'd51);
        check("to_rails_off", 32'(rail_en), 32'(INH));
        check("to_power_ok", 32'(power_ok), 32'd0);
        wb_read(16'd3, rd);
        check("to_fault_rail", 32'(rd), 32'd2);
        wb_read(16'd0, rd);
        check("to_cause", 32'(rd[7:6]), 32'd1);
        check("to_state", 32'(rd[3:0]), 32'd7);
        // Up command in FAULT is ignored
        wb_write(16'd1, 16'h0001);
        wb_read(16'd0, rd);
        check("to_up_ignored", 32'(rd[3:0]), 32'd7);
        pg_force = 4'hF;
        wb_write(16'd1, 16'h0004);
        wait_off("to_clear_off");

        // Health fault in ON
        power_up(4'hF);
        fault = 1'b1;
        tick();
        fault = 1'b0;
        check("hf_seq_fault", 32'(seq_fault), 32'd1);
        check("hf_rails_off", 32'(rail_en), 32'(INH));
        check("hf_power_ok", 32'(power_ok), 32'd0);
        wb_read(16'd0, rd);
        check("hf_cause", 32'(rd[7:6]), 32'd3);
        wb_write(16'd1, 16'h0004);
        wb_read(16'd0, rd);
        check("hf_clear_state", 32'(rd[5:0]), 32'd0);

        // PG loss on rail 0 in ON
        power_up(4'hF);
        pg_force = 4'b1110;
        c = 0;
        while (!seq_fault && c < 10) begin
            tick();
            c++;
        end
        check("pl_seq_fault", 32'(seq_fault), 32'd1);
        check("pl_rails_off", 32'(rail_en), 32'(INH));
        wb_read(16'd0, rd);
        check("pl_cause", 32'(rd[7:6]), 32'd2);
        wb_read(16'd3, rd);
        check("pl_fault_rail", 32'(rd), 32'd0);
        pg_force = 4'hF;
        wb_write(16'd1, 16'h0004);
        wait_off("pl_clear_off");

        // Enable mask 1010
        wb_write(16'd4, 16'h000A);
        wb_read(16'd4, rd);
        check("mask_write_off", 32'(rd), 32'hA);
        power_up(4'hA);
        check("mask_rails", 32'(en_log()), 32'hA);
        wb_write(16'd4, 16'h000F);
        wb_read(16'd4, rd);
        check("mask_write_on_ignored", 32'(rd), 32'hA);
        power_down(4'hA);
        wb_write(16'd4, 16'h000F);

        // Asynchronous reset mid-sequence
        wb_write(16'd1, 16'h0001);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("ar_rails_off", 32'(rail_en), 32'(INH));
        check("ar_power_ok", 32'(power_ok), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        wb_read(16'd0, rd);
        check("ar_status", 32'(rd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
